// File: rtl/cart_loader_if.sv
// rtl/cart_loader_if.sv - ioctl download stream and SDRAM write-port bundle for cart_loader
// master = HPS/SDRAM side, slave = cart_loader.
interface cart_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [23:0] sd_waddr;
    logic [7:0]  sd_din;
    logic        sd_we;
    logic        sd_we_ack;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sd_we_ack,
        input  ioctl_wait, sd_waddr, sd_din, sd_we
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sd_we_ack,
        output ioctl_wait, sd_waddr, sd_din, sd_we
    );
endinterface

// File: rtl/cart_loader.sv
// rtl/cart_loader.sv - cartridge download into SDRAM plus runtime ROM address translation
// Optional macro CART_HEADER_SKIP_EN: enables 512-byte copier header detection and skip.
module cart_loader #(
    parameter int ROM_AW = 22
) (
    input  logic              clk_sys,
    input  logic              RESET_n,
    cart_loader_if.slave      bus,
    input  logic [ROM_AW-1:0] rd_addr,
    output logic [23:0]       rd_addr_out,
    output logic              gg,
    output logic              hdr,
    output logic              dbr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACK    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        dl_q, dl_d;
    logic [23:0] sd_waddr_q, sd_waddr_d;
    logic [24:0] cnt_q, cnt_d;
    logic [7:0]  sd_din_q, sd_din_d;
    logic        sd_we_q, sd_we_d;
    logic        wait_q, wait_d;
    logic [21:0] mask_q, mask_d;
    logic        gg_q, gg_d;
    logic        dbr_q, dbr_d;
    logic [23:0] rd_addr_out_q, rd_addr_out_d;
    logic        hdr_q;

    logic [23:0] rd_ext;
    logic [23:0] mask_ext;
    logic [21:0] mask_upd;
    logic        dl_rise;
    logic [2:0]  unused_index;

    assign unused_index = bus.ioctl_index[7:5];
    assign dl_rise      = bus.ioctl_download && !dl_q;
    assign rd_ext       = 24'(rd_addr);
    assign mask_ext     = {2'b00, mask_q};
    assign mask_upd     = (bus.ioctl_addr == 25'd0) ? 22'd0 : (mask_q | bus.ioctl_addr[21:0]);

`ifdef CART_HEADER_SKIP_EN
    logic [21:0] mask512_q, mask512_d;
    logic [21:0] mask512_upd;
    logic [23:0] mask512_ext;
    logic        hdr_d;

    // Offsets are relative to the end of the copier header.
    assign mask512_upd = (bus.ioctl_addr == 25'd512) ? 22'd0
                       : (mask512_q | (bus.ioctl_addr[21:0] - 22'd512));
    assign mask512_ext = {2'b00, mask512_q};
`endif

    always_comb begin
        state_d    = state_q;
        dl_d       = bus.ioctl_download;
        sd_waddr_d = sd_waddr_q;
        cnt_d      = cnt_q;
        sd_din_d   = sd_din_q;
        sd_we_d    = sd_we_q;
        wait_d     = wait_q;
        mask_d     = mask_q;
        gg_d       = gg_q;
        dbr_d      = dbr_q;
`ifdef CART_HEADER_SKIP_EN
        mask512_d  = mask512_q;
        hdr_d      = hdr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (dl_rise) begin
                    state_d    = ST_LOAD;
                    sd_waddr_d = 24'd0;
                    cnt_d      = 25'd0;
                    dbr_d      = 1'b1;
                end
            end
            ST_LOAD: begin
                if (!bus.ioctl_download) begin
                    state_d = ST_FINISH;
                end else if (bus.ioctl_wr) begin
                    state_d  = ST_ACK;
                    sd_din_d = bus.ioctl_dout;
                    sd_we_d  = ~sd_we_q;
                    wait_d   = 1'b1;
                    mask_d   = mask_upd;
                    gg_d     = (bus.ioctl_index[4:0] == 5'd2);
`ifdef CART_HEADER_SKIP_EN
                    if (bus.ioctl_addr >= 25'd512) begin
                        mask512_d = mask512_upd;
                    end
`endif
                end
            end
            ST_ACK: begin
                // A download that ended meanwhile is honoured only once this write lands.
                if (bus.sd_we_ack == sd_we_q) begin
                    wait_d     = 1'b0;
                    sd_waddr_d = sd_waddr_q + 24'd1;
                    cnt_d      = cnt_q + 25'd1;
                    state_d    = bus.ioctl_download ? ST_LOAD : ST_FINISH;
                end
            end
            ST_FINISH: begin
`ifdef CART_HEADER_SKIP_EN
                hdr_d = cnt_q[9];
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_addr_out_d = rd_ext & mask_ext;
`ifdef CART_HEADER_SKIP_EN
        if (hdr_q) begin
            rd_addr_out_d = (rd_ext & mask512_ext) + 24'd512;
        end
`endif
    end

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q       <= ST_IDLE;
            dl_q          <= 1'b0;
            sd_waddr_q    <= 24'd0;
            cnt_q         <= 25'd0;
            sd_din_q      <= 8'd0;
            sd_we_q       <= 1'b0;
            wait_q        <= 1'b0;
            mask_q        <= 22'd0;
            gg_q          <= 1'b0;
            dbr_q         <= 1'b0;
            rd_addr_out_q <= 24'd0;
        end else begin
            state_q       <= state_d;
            dl_q          <= dl_d;
            sd_waddr_q    <= sd_waddr_d;
            cnt_q         <= cnt_d;
            sd_din_q      <= sd_din_d;
            sd_we_q       <= sd_we_d;
            wait_q        <= wait_d;
            mask_q        <= mask_d;
            gg_q          <= gg_d;
            dbr_q         <= dbr_d;
            rd_addr_out_q <= rd_addr_out_d;
        end
    end

`ifdef CART_HEADER_SKIP_EN
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            mask512_q <= 22'd0;
            hdr_q     <= 1'b0;
        end else begin
            mask512_q <= mask512_d;
            hdr_q     <= hdr_d;
        end
    end
`else
    assign hdr_q = 1'b0;
`endif

    assign bus.ioctl_wait = wait_q;
    assign bus.sd_waddr   = sd_waddr_q;
    assign bus.sd_din     = sd_din_q;
    assign bus.sd_we      = sd_we_q;
    assign rd_addr_out    = rd_addr_out_q;
    assign gg             = gg_q;
    assign hdr            = hdr_q;
    assign dbr            = dbr_q;

endmodule

// File: tb/tb_cart_loader.sv
// tb/tb_cart_loader.sv - scoreboard bench for cart_loader (SDRAM writes, masks, header, reset)
module tb_cart_loader;
    localparam int ROM_AW = 22;
`ifdef CART_HEADER_SKIP_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    cart_loader_if bus();
    logic [ROM_AW-1:0] rd_addr;
    logic [23:0]       rd_addr_out;
    logic              gg;
    logic              hdr;
    logic              dbr;

    cart_loader #(.ROM_AW(ROM_AW)) dut (
        .clk_sys     (clk_sys),
        .RESET_n     (rst_n),
        .bus         (bus),
        .rd_addr     (rd_addr),
        .rd_addr_out (rd_addr_out),
        .gg          (gg),
        .hdr         (hdr),
        .dbr         (dbr)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    int          ack_delay   = 1;
    int          wcount      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // SDRAM side: echo each toggle after ack_delay cycles.
    initial begin
        int pend;
        pend = 0;
        bus.sd_we_ack = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (!rst_n) begin
                bus.sd_we_ack = 1'b0;
                pend = 0;
            end else if (bus.sd_we != bus.sd_we_ack) begin
                pend++;
                if (pend >= ack_delay) begin
                    bus.sd_we_ack = bus.sd_we;
                    pend = 0;
                end
            end
        end
    end

    // Monitor: every sd_we toggle is one write request, checked against the queue.
    initial begin
        logic        prev;
        logic [31:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (!rst_n) begin
                prev = bus.sd_we;
            end else if (bus.sd_we !== prev) begin
                prev = bus.sd_we;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write actual=waddr 0x%0h din 0x%0h required=no write",
                             bus.sd_waddr, bus.sd_din);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", {8'h00, bus.sd_waddr}, {8'h00, e[31:8]});
                    check("wr_data", {24'h0, bus.sd_din}, {24'h0, e[7:0]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        while (bus.ioctl_wait && n < 300) begin
            tick();
            n++;
        end
        if (bus.ioctl_wait) check("wait_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue_wr(input logic [24:0] addr, input logic [7:0] data);
        exp_q.push_back({wcount[23:0], data});
        wcount++;
        tick();
        bus.ioctl_addr = addr;
        bus.ioctl_dout = data;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
        issue_wr(addr, data);
        wait_ack();
    endtask

    task automatic start_dl(input logic [7:0] idx);
        tick();
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        wcount = 0;
    endtask

    task automatic end_dl();
        tick();
        bus.ioctl_download = 1'b0;
        repeat (4) tick();
    endtask

    task automatic rd_check(input string name, input logic [ROM_AW-1:0] a, input logic [23:0] exp);
        rd_addr = a;
        tick();
        check(name, {8'h00, rd_addr_out}, {8'h00, exp});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wait"},  {31'd0, bus.ioctl_wait}, 32'd0);
        check({tag, "_we"},    {31'd0, bus.sd_we}, 32'd0);
        check({tag, "_waddr"}, {8'd0, bus.sd_waddr}, 32'd0);
        check({tag, "_din"},   {24'd0, bus.sd_din}, 32'd0);
        check({tag, "_rdout"}, {8'd0, rd_addr_out}, 32'd0);
        check({tag, "_gg"},    {31'd0, gg}, 32'd0);
        check({tag, "_hdr"},   {31'd0, hdr}, 32'd0);
        check({tag, "_dbr"},   {31'd0, dbr}, 32'd0);
    endtask

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = 25'd0;
        bus.ioctl_dout     = 8'd0;
        rd_addr            = 22'h3FFFFF;

        repeat (2) @(negedge clk_sys);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Header-free 1 KiB image, ack echoed 3 cycles after each toggle.
        ack_delay = 3;
        start_dl(8'd1);
        for (int i = 0; i < 1024; i++) send_byte(25'(i), 8'(i * 7 + 3));
        end_dl();
        check("plain_hdr",   {31'd0, hdr}, 32'd0);
        check("plain_gg",    {31'd0, gg}, 32'd0);
        check("plain_dbr",   {31'd0, dbr}, 32'd1);
        check("plain_waddr", {8'd0, bus.sd_waddr}, 32'h400);
        rd_check("plain_rd_8123", 22'h008123, 24'h000123);
        rd_check("plain_rd_max",  22'h3FFFFF, 24'h0003FF);

        // 1536-byte image: 1 KiB payload behind a 512-byte copier header.
        ack_delay = 1;
        start_dl(8'd1);
        for (int i = 0; i < 1536; i++) send_byte(25'(i), 8'(i ^ 8'hA5));
        end_dl();
        check("hdr_flag",  {31'd0, hdr}, {31'd0, HS});
        check("hdr_waddr", {8'd0, bus.sd_waddr}, 32'h600);
        rd_check("hdr_rd_0",    22'h000000, HS ? 24'h000200 : 24'h000000);
        rd_check("hdr_rd_3ff",  22'h0003FF, HS ? 24'h0005FF : 24'h0003FF);
        rd_check("hdr_rd_8123", 22'h008123, HS ? 24'h000323 : 24'h000123);

        // GG image with a 50-cycle ack stall and a spurious strobe inside it.
        start_dl(8'd2);
        ack_delay = 51;
        issue_wr(25'd0, 8'hC3);
        for (int i = 0; i < 50; i++) begin
            check("stall_wait",  {31'd0, bus.ioctl_wait}, 32'd1);
            check("stall_waddr", {8'd0, bus.sd_waddr}, 32'd0);
            if (i == 10) bus.ioctl_wr = 1'b1;
            if (i == 11) bus.ioctl_wr = 1'b0;
            tick();
        end
        wait_ack();
        check("stall_waddr_after", {8'd0, bus.sd_waddr}, 32'd1);
        ack_delay = 1;
        for (int i = 1; i < 4; i++) send_byte(25'(i), 8'(8'h10 + i));
        end_dl();
        check("gg_set",   {31'd0, gg}, 32'd1);
        check("gg_dbr",   {31'd0, dbr}, 32'd1);
        check("gg_hdr",   {31'd0, hdr}, 32'd0);

        // 512-byte image whose download drops while the last ack is pending.
        start_dl(8'd1);
        for (int i = 0; i < 511; i++) send_byte(25'(i), 8'(i + 1));
        ack_delay = 6;
        issue_wr(25'd511, 8'h5E);
        bus.ioctl_download = 1'b0;
        check("late_wait", {31'd0, bus.ioctl_wait}, 32'd1);
        wait_ack();
        check("late_waddr", {8'd0, bus.sd_waddr}, 32'h200);
        ack_delay = 1;
        repeat (3) tick();
        check("late_hdr", {31'd0, hdr}, {31'd0, HS});
        check("late_gg",  {31'd0, gg}, 32'd0);
        check("late_dbr", {31'd0, dbr}, 32'd1);
        // mask512 keeps the previous image's value since no byte reached offset 512.
        rd_check("late_rd_1234", 22'h001234, HS ? 24'h000434 : 24'h000034);

        // Strobe outside a download must not write.
        tick();
        bus.ioctl_addr = 25'd5;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr   = 1'b0;
        repeat (4) tick();
        check("idle_wr_waddr", {8'd0, bus.sd_waddr}, 32'h200);
        check("idle_wr_wait",  {31'd0, bus.ioctl_wait}, 32'd0);

        // Asynchronous reset while a write is pending.
        start_dl(8'd1);
        ack_delay = 40;
        issue_wr(25'd0, 8'h77);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        bus.ioctl_download = 1'b0;
        #1;
        check_all_zero("async");
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b1;
        ack_delay = 1;
        repeat (3) tick();
        check("post_reset_dbr",   {31'd0, dbr}, 32'd0);
        check("post_reset_waddr", {8'd0, bus.sd_waddr}, 32'd0);
        start_dl(8'd1);
        send_byte(25'd0, 8'h11);
        send_byte(25'd1, 8'h22);
        end_dl();
        check("restart_waddr", {8'd0, bus.sd_waddr}, 32'd2);
        check("restart_dbr",   {31'd0, dbr}, 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
